ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter in the Flounder CPLD. It sends command bytes (LED set 0xED, reset 0xFF, typematic 0xF3, and others) from the Z180 to the keyboard over the same open-drain KB_CLK/KB_DATA pair the scancode receiver listens on. The CPU-facing decode hands it a byte and a start strobe. The block then performs the full request-to-send handshake, shifts out the frame, checks the device ACK and reports the result. While a transmit is in progress it asserts an inhibit output so the receiver ignores the bus.

## Interface
- INHIBIT_CYCLES, 2048: CLK cycles KB_CLK is held low before the clock is released (at least 100 us at 18.432 MHz).
- FILTER_CYCLES, 8: cycles KB_CLK must be stable before an edge is accepted.
- TIMEOUT_CYCLES, 262144: frame watchdog limit (about 14 ms). Only present with PS2_TX_TIMEOUT_EN.
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-low reset.
- TX_DATA  in  8  command byte, sampled on the cycle TX_START is accepted.
- TX_START  in  1  one-cycle request strobe.
- KB_CLK_IN  in  1  raw PS/2 clock pin (asynchronous).
- KB_DATA_IN  in  1  raw PS/2 data pin (asynchronous).
- KB_CLK_OE  out  1  1 = pull KB_CLK low. The top level drives the pin low when this is 1, otherwise Z.
- KB_DATA_OE  out  1  1 = pull KB_DATA low. Same open-drain handling.
- BUSY  out  1  high from acceptance until DONE or ERR.
- RX_INHIBIT  out  1  equal to BUSY; the receiver must discard bits while this is high.
- DONE  out  1  one-cycle pulse: frame sent and ACK received.
- ERR  out  1  one-cycle pulse: frame failed.
- ERR_CODE  out  2  00 none, 01 NACK, 10 timeout. Held until the next accept.

## Operation
- KB_CLK_IN and KB_DATA_IN each pass through a 2-flop synchronizer. KB_CLK is then deglitched, and a falling edge (fall) is a one-cycle event on the filtered clock.
- Odd parity: par = ~^TX_DATA.
- State machine:
  - IDLE: all OE = 0, BUSY = 0. When TX_START is high, latch TX_DATA, compute par, clear ERR_CODE, go to INHIBIT.
  - INHIBIT: KB_CLK_OE = 1, counter runs. At count INHIBIT_CYCLES-8, set KB_DATA_OE = 1 (start bit). At count INHIBIT_CYCLES, set KB_CLK_OE = 0, clear bit index, go to SHIFT.
  - SHIFT: on each fall, index 0-7 sets KB_DATA_OE = ~data[index] (LSB first), index 8 sets KB_DATA_OE = ~par, and index 9 sets KB_DATA_OE = 0 (stop bit; data released). Index increments each fall. After index 9, go to ACK.
  - ACK: on the next fall, sample synchronized data. If it is 0, go to RELEASE. If it is 1, set ERR_CODE = 01 and go to FAIL.
  - RELEASE: wait until filtered clock = 1 and data = 1, then go to FIN.
  - FIN: DONE pulse, go to IDLE.
  - FAIL: all OE = 0, ERR pulse, go to IDLE.
- TX_START is ignored while BUSY = 1. There is no queueing.
- Reset values: KB_CLK_OE = 0, KB_DATA_OE = 0, BUSY = 0, RX_INHIBIT = 0, DONE = 0, ERR = 0, ERR_CODE = 00, state IDLE. If RST goes low mid-frame, both lines are released on the next CLK edge.

## Timing
- Accept to KB_CLK_OE high: 1 cycle, since all outputs are registered.
- The start bit is asserted 8 cycles before the clock is released.
- The data bit changes 1 cycle after the fall event. The device samples on the rising edge, so setup is at least half a PS/2 clock, about 30 us.
- DONE or ERR pulses exactly 1 cycle. BUSY falls in the same cycle as that pulse.
- The filter adds FILTER_CYCLES+2 cycles of latency to every edge. All tolerances apply to a 10-16.7 kHz device clock.

## Configuration
- PS2_TX_TIMEOUT_EN defined: a watchdog counts from the INHIBIT-to-SHIFT transition. If it reaches TIMEOUT_CYCLES in SHIFT, ACK or RELEASE, set ERR_CODE = 10 and go to FAIL. The counter resets on every accept.
- PS2_TX_TIMEOUT_EN undefined: no watchdog. A silent device leaves the block in SHIFT until RST, and ERR_CODE = 10 is never produced.

## Structure
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, SHIFT, ACK, RELEASE, FIN, FAIL);
  - the ERR_CODE constants;
  - the index constants IDX_PARITY = 8 and IDX_STOP = 9.
- Sub-module ps2_line_filter contains the synchronizer, the deglitch and the fall event. It is intended to be shared with the scancode receiver.

## Test plan
- Send 0xED with a device model that ACKs: the model samples 0,1,0,1,1,0,1,1,1 (start, data LSB first, parity = 1), then sees the stop bit = 1 -> DONE pulse, ERR_CODE = 00.
- Send 0x01: the model sees data 1,0,0,0,0,0,0,0 and parity = 0 -> DONE.
- Model drives ACK bit high, on 0xFF -> ERR pulse, ERR_CODE = 01, both OE = 0 afterwards.
- TX_START again while BUSY, with TX_DATA = 0x55 -> ignored; the first frame completes unchanged.
- RST low in the middle of the index-4 bit -> next cycle KB_CLK_OE = 0, KB_DATA_OE = 0, BUSY = 0.
- With PS2_TX_TIMEOUT_EN defined and a device that never clocks -> ERR after TIMEOUT_CYCLES, ERR_CODE = 10.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter.
//   ps2_state_e     transmitter FSM states
//   ERR_*           ERR_CODE encodings reported to the CPU
//   IDX_PARITY/STOP bit-index values for the parity and stop slots of a frame
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SHIFT,
    ACK,
    RELEASE,
    FIN,
    FAIL
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [3:0] IDX_PARITY = 4'd8;
  localparam logic [3:0] IDX_STOP   = 4'd9;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronizes the raw PS/2 clock and data pins and deglitches
// the clock. Shared between the host transmitter and the scancode receiver.
//   CLK, RST     system clock, synchronous active-low reset
//   kb_clk_i     raw KB_CLK pin (asynchronous)
//   kb_data_i    raw KB_DATA pin (asynchronous)
//   clk_filt_o   deglitched KB_CLK level
//   fall_o       one-cycle pulse when clk_filt_o goes 1 -> 0
//   data_sync_o  synchronized KB_DATA level
module ps2_line_filter #(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic kb_clk_i,
  input  logic kb_data_i,
  output logic clk_filt_o,
  output logic fall_o,
  output logic data_sync_o
);

  localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] FLT_LOAD = CW'(FILTER_CYCLES - 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          clk_filt_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  // The counter reloads whenever the synchronized clock agrees with the
  // filtered one, so only an uninterrupted run of FILTER_CYCLES differing
  // samples moves the filtered level.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      fall_q      <= 1'b0;
      cnt_q       <= FLT_LOAD;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], kb_clk_i};
      data_sync_q <= {data_sync_q[0], kb_data_i};
      fall_q      <= 1'b0;
      if (clk_sync_q[1] == clk_filt_q) begin
        cnt_q <= FLT_LOAD;
      end else if (cnt_q == '0) begin
        clk_filt_q <= clk_sync_q[1];
        fall_q     <= ~clk_sync_q[1];
        cnt_q      <= FLT_LOAD;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign clk_filt_o  = clk_filt_q;
  assign fall_o      = fall_q;
  assign data_sync_o = data_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Performs request-to-send,
// shifts out start/data/parity/stop, checks the device ACK, reports status.
//   CLK, RST                system clock, synchronous active-low reset
//   TX_DATA, TX_START       command byte and one-cycle request strobe
//   KB_CLK_IN, KB_DATA_IN   raw open-drain pin levels
//   KB_CLK_OE, KB_DATA_OE   1 = pull the line low
//   BUSY, RX_INHIBIT        high from accept until DONE/ERR
//   DONE, ERR               one-cycle result pulses
//   ERR_CODE                00 none, 01 NACK, 10 timeout; held until next accept
// Optional: define PS2_TX_TIMEOUT_EN to add the frame watchdog (TIMEOUT_CYCLES).
//
// state   | meaning
// IDLE    | lines released, waiting for TX_START
// INHIBIT | KB_CLK held low; start bit placed 8 cycles before release
// SHIFT   | drive data, parity, stop on each device clock fall
// ACK     | sample device ACK on the next fall
// RELEASE | wait for bus idle (clock and data high)
// FIN     | DONE pulse
// FAIL    | ERR pulse, lines released
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2048,
  parameter int unsigned FILTER_CYCLES  = 8
`ifdef PS2_TX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 262144
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  input  logic       KB_CLK_IN,
  input  logic       KB_DATA_IN,
  output logic       KB_CLK_OE,
  output logic       KB_DATA_OE,
  output logic       BUSY,
  output logic       RX_INHIBIT,
  output logic       DONE,
  output logic       ERR,
  output logic [1:0] ERR_CODE
);

  localparam int unsigned ICW = $clog2(INHIBIT_CYCLES);
  localparam logic [ICW-1:0] INH_LOAD  = ICW'(INHIBIT_CYCLES - 1);
  localparam logic [ICW-1:0] INH_START = ICW'(8);

  logic clk_filt, fall, data_s;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
    .CLK        (CLK),
    .RST        (RST),
    .kb_clk_i   (KB_CLK_IN),
    .kb_data_i  (KB_DATA_IN),
    .clk_filt_o (clk_filt),
    .fall_o     (fall),
    .data_sync_o(data_s)
  );

  ps2_state_e     state_q, state_d;
  logic [ICW-1:0] inh_q, inh_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     data_q, data_d;
  logic           par_q, par_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           clk_oe_q, clk_oe_d;
  logic           data_oe_q, data_oe_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WCW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WCW-1:0] WD_LOAD = WCW'(TIMEOUT_CYCLES - 1);
  logic [WCW-1:0] wd_q, wd_d;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      inh_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      inh_q      <= inh_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      par_q      <= par_d;
      err_code_q <= err_code_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    inh_d      = inh_q;
    idx_d      = idx_q;
    data_d     = data_q;
    par_d      = par_q;
    err_code_d = err_code_q;
    clk_oe_d   = 1'b0;
    data_oe_d  = data_oe_q;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d       = wd_q;
`endif
    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (TX_START) begin
          data_d     = TX_DATA;
          par_d      = ~^TX_DATA;
          err_code_d = ERR_NONE;
          inh_d      = INH_LOAD;
          clk_oe_d   = 1'b1;
          state_d    = INHIBIT;
`ifdef PS2_TX_TIMEOUT_EN
          wd_d       = WD_LOAD;
`endif
        end
      end
      INHIBIT: begin
        clk_oe_d = 1'b1;
        if (inh_q == INH_START) data_oe_d = 1'b1;
        if (inh_q == '0) begin
          clk_oe_d = 1'b0;
          idx_d    = '0;
          state_d  = SHIFT;
`ifdef PS2_TX_TIMEOUT_EN
          wd_d     = WD_LOAD;
`endif
        end else begin
          inh_d = inh_q - ICW'(1);
        end
      end
      SHIFT: begin
        if (fall) begin
          if (idx_q < IDX_PARITY)       data_oe_d = ~data_q[idx_q[2:0]];
          else if (idx_q == IDX_PARITY) data_oe_d = ~par_q;
          else                          data_oe_d = 1'b0;
          idx_d = idx_q + 4'd1;
          if (idx_q == IDX_STOP) state_d = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          if (!data_s) begin
            state_d = RELEASE;
          end else begin
            err_code_d = ERR_NACK;
            state_d    = FAIL;
          end
        end
      end
      RELEASE: if (clk_filt && data_s) state_d = FIN;
      FIN:     state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog covers everything after the clock is released; it overrides
    // whatever the frame logic decided this cycle.
    if (state_q inside {SHIFT, ACK, RELEASE}) begin
      if (wd_q == '0) begin
        err_code_d = ERR_TIMEOUT;
        state_d    = FAIL;
      end else begin
        wd_d = wd_q - WCW'(1);
      end
    end
`endif
    if (state_d == FAIL) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end
    // Status outputs are registered from the next state so BUSY drops in
    // the same cycle the DONE/ERR pulse appears.
    done_d = (state_d == FIN);
    err_d  = (state_d == FAIL);
    busy_d = !(state_d inside {IDLE, FIN, FAIL});
  end

  assign KB_CLK_OE  = clk_oe_q;
  assign KB_DATA_OE = data_oe_q;
  assign BUSY       = busy_q;
  assign RX_INHIBIT = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign ERR_CODE   = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int FLT  = 4;
  localparam int HALF = 25;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int TMO  = 3000;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_START = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       kb_clk_pin, kb_data_pin;
  logic       KB_CLK_OE, KB_DATA_OE, BUSY, RX_INHIBIT, DONE, ERR;
  logic [1:0] ERR_CODE;

  assign kb_clk_pin  = ~(KB_CLK_OE | dev_clk_low);
  assign kb_data_pin = ~(KB_DATA_OE | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_CYCLES (FLT)
`ifdef PS2_TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .TX_DATA   (TX_DATA),
    .TX_START  (TX_START),
    .KB_CLK_IN (kb_clk_pin),
    .KB_DATA_IN(kb_data_pin),
    .KB_CLK_OE (KB_CLK_OE),
    .KB_DATA_OE(KB_DATA_OE),
    .BUSY      (BUSY),
    .RX_INHIBIT(RX_INHIBIT),
    .DONE      (DONE),
    .ERR       (ERR),
    .ERR_CODE  (ERR_CODE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  int         done_cnt = 0, err_cnt = 0, busy_at_pulse = 0, wide_pulse = 0, inh_mismatch = 0;
  logic [1:0] code_at_err = 2'b00;
  logic       prev_done = 1'b0, prev_err = 1'b0;

  always @(negedge CLK) begin
    if (DONE) begin done_cnt++; if (BUSY) busy_at_pulse++; end
    if (ERR) begin err_cnt++; code_at_err = ERR_CODE; if (BUSY) busy_at_pulse++; end
    if ((DONE && prev_done) || (ERR && prev_err)) wide_pulse++;
    if (RX_INHIBIT !== BUSY) inh_mismatch++;
    prev_done = DONE;
    prev_err  = ERR;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge CLK);
    TX_DATA  = b;
    TX_START = 1'b1;
    @(negedge CLK);
    TX_START = 1'b0;
    check("accept_clk_oe", KB_CLK_OE, 1'b1);
    check("accept_busy", BUSY, 1'b1);
  endtask

  // Device model: entered on the first negedge after accept. frame[0]=start,
  // [8:1]=data LSB first, [9]=parity, [10]=stop as seen on device rising edges.
  task automatic dev_frame(input int abort_at, input logic ack_low, output logic [10:0] frame,
                           output int clk_hi, output int start_lead);
    int k;
    int t_data;
    k = 1;
    t_data = -1;
    frame = '1;
    while (KB_CLK_OE && k < 1000) begin
      if (KB_DATA_OE && t_data < 0) t_data = k;
      @(negedge CLK);
      k++;
    end
    clk_hi = k - 1;
    start_lead = (t_data < 0) ? -1 : k - t_data;
    frame[0] = kb_data_pin;
    repeat (20) @(negedge CLK);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == abort_at) begin
        repeat (15) @(negedge CLK);
        return;
      end
      repeat (HALF) @(negedge CLK);
      dev_clk_low = 1'b0;
      frame[i] = kb_data_pin;
      repeat (HALF) @(negedge CLK);
    end
    dev_data_low = ack_low;
    dev_clk_low  = 1'b1;
    repeat (HALF) @(negedge CLK);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge CLK);
    dev_data_low = 1'b0;
  endtask

  logic [10:0] frame;
  int          clk_hi, lead, n;

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_clk_oe", KB_CLK_OE, 1'b0);
    check("rst_data_oe", KB_DATA_OE, 1'b0);
    check("rst_busy_inh_done_err", {BUSY, RX_INHIBIT, DONE, ERR}, 4'b0000);
    check("rst_err_code", ERR_CODE, 2'b00);
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    // 0xED with ACK; a second TX_START (0x55) mid-frame must be ignored
    start_tx(8'hED);
    fork
      dev_frame(-1, 1'b1, frame, clk_hi, lead);
      begin
        repeat (200) @(negedge CLK);
        TX_DATA  = 8'h55;
        TX_START = 1'b1;
        @(negedge CLK);
        TX_START = 1'b0;
        TX_DATA  = 8'h00;
      end
    join
    check("ed_inhibit_len", clk_hi, INH);
    check("ed_start_lead", lead, 8);
    check("ed_frame", frame, {1'b1, 1'b1, 8'hED, 1'b0});
    n = 0;
    while (!(DONE || ERR) && n < 200) begin @(negedge CLK); n++; end
    check("ed_pulse_seen", n < 200, 1'b1);
    check("ed_done", {DONE, ERR, BUSY}, 3'b100);
    check("ed_err_code", ERR_CODE, 2'b00);
    @(negedge CLK);
    check("ed_done_width", DONE, 1'b0);
    repeat (50) @(negedge CLK);
    check("busy_start_ignored", {KB_CLK_OE, BUSY}, 2'b00);
    check("ed_done_cnt", done_cnt, 1);

    // 0x01 with ACK
    start_tx(8'h01);
    dev_frame(-1, 1'b1, frame, clk_hi, lead);
    check("x01_frame", frame, {1'b1, 1'b0, 8'h01, 1'b0});
    n = 0;
    while (!(DONE || ERR) && n < 200) begin @(negedge CLK); n++; end
    check("x01_done", {DONE, ERR, BUSY}, 3'b100);
    repeat (5) @(negedge CLK);
    check("x01_done_cnt", done_cnt, 2);

    // 0xFF with NACK
    start_tx(8'hFF);
    dev_frame(-1, 1'b0, frame, clk_hi, lead);
    check("ff_frame", frame, {1'b1, 1'b1, 8'hFF, 1'b0});
    repeat (5) @(negedge CLK);
    check("ff_err_cnt", err_cnt, 1);
    check("ff_code_at_err", code_at_err, 2'b01);
    check("ff_err_code_held", ERR_CODE, 2'b01);
    check("ff_lines_released", {KB_CLK_OE, KB_DATA_OE, BUSY}, 3'b000);
    check("ff_no_done", done_cnt, 2);

    // Reset in the middle of the index-4 bit of 0xED (bit4 = 0 -> data pulled)
    start_tx(8'hED);
    check("accept_clears_code", ERR_CODE, 2'b00);
    dev_frame(5, 1'b1, frame, clk_hi, lead);
    check("mid_bit4_data_oe", {KB_DATA_OE, BUSY}, 2'b11);
    RST = 1'b0;
    @(negedge CLK);
    check("mid_rst_release", {KB_CLK_OE, KB_DATA_OE, BUSY}, 3'b000);
    dev_clk_low = 1'b0;
    RST = 1'b1;
    repeat (20) @(negedge CLK);

    // Silent device
    start_tx(8'h3C);
    n = 0;
    while (KB_CLK_OE && n < 200) begin @(negedge CLK); n++; end
    check("silent_clk_released", KB_CLK_OE, 1'b0);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!(DONE || ERR) && n < TMO + 100) begin @(negedge CLK); n++; end
    check("tmo_latency", n, TMO);
    check("tmo_err", {ERR, DONE, BUSY}, 3'b100);
    check("tmo_err_code", ERR_CODE, 2'b10);
    repeat (3) @(negedge CLK);
    check("tmo_err_cnt", err_cnt, 2);
`else
    repeat (500) @(negedge CLK);
    check("silent_still_busy", BUSY, 1'b1);
    check("silent_no_code", ERR_CODE, 2'b00);
    check("silent_err_cnt", err_cnt, 1);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
`endif

    check("pulse_busy_low", busy_at_pulse, 0);
    check("pulse_width_one", wide_pulse, 0);
    check("rx_inhibit_eq_busy", inh_mismatch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
